assoc_cache: RTL and testbench

- N-way set-associative, write-back, write-allocate cache. It generalises the direct-mapped per-set cache to a parametrised associativity with age-based LRU replacement.
- The memory port uses a request/ready handshake with word-by-word line transfer, which tolerates multi-cycle memory latency.
- Sits between the pipeline and main memory. One instance serves instructions and one serves data, both sharing the pipeline stall.

---
 rtl/cache_pkg.sv | 15 +
 rtl/cache_way.sv | 59 +++++
 rtl/assoc_cache.sv | 182 ++++++++++++++++++
 tb/tb_assoc_cache.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared defaults, state encoding and helpers for the set-associative cache.
`define CACHE_T 26
`define CACHE_S 2
`define CACHE_B 4
`define CACHE_E 2
`define STATE_WIDTH 2

package cache_pkg;
    typedef enum logic [`STATE_WIDTH-1:0] {IDLE, WRITEBACK, REFILL} state_t;

    // Width of a per-way age counter; never zero so arrays stay legal.
    function automatic int age_width(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction
endpackage

// File: rtl/cache_way.sv
// One way of the cache: valid/dirty/tag/data for every set, with a
// combinational read port and a word/line-meta write port.
module cache_way
    import cache_pkg::*;
#(
    parameter int TAG_WIDTH    = `CACHE_T,
    parameter int SET_WIDTH    = `CACHE_S,
    parameter int OFFSET_WIDTH = `CACHE_B
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SET_WIDTH-1:0]    rd_index_i,
    input  logic [OFFSET_WIDTH-3:0] rd_word_i,
    input  logic [TAG_WIDTH-1:0]    cmp_tag_i,
    output logic                    match_o,
    output logic                    valid_o,
    output logic                    dirty_o,
    output logic [TAG_WIDTH-1:0]    tag_o,
    output logic [31:0]             word_o,
    input  logic                    wr_en_i,
    input  logic [SET_WIDTH-1:0]    wr_index_i,
    input  logic [OFFSET_WIDTH-3:0] wr_word_i,
    input  logic [31:0]             wr_data_i,
    input  logic                    wr_dirty_i,
    input  logic                    meta_en_i,
    input  logic [TAG_WIDTH-1:0]    meta_tag_i
);
    localparam int SETS  = 2**SET_WIDTH;
    localparam int WORDS = 2**(OFFSET_WIDTH-2);

    logic [SETS-1:0]      valid_q, dirty_q;
    logic [TAG_WIDTH-1:0] tag_q  [SETS];
    logic [31:0]          data_q [SETS][WORDS];

    assign valid_o = valid_q[rd_index_i];
    assign dirty_o = dirty_q[rd_index_i];
    assign tag_o   = tag_q[rd_index_i];
    assign word_o  = data_q[rd_index_i][rd_word_i];
    assign match_o = valid_o && (tag_o == cmp_tag_i);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (wr_en_i && wr_dirty_i) dirty_q[wr_index_i] <= 1'b1;
            // Line install wins over any word write in the same cycle.
            if (meta_en_i) begin
                valid_q[wr_index_i] <= 1'b1;
                dirty_q[wr_index_i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i)   data_q[wr_index_i][wr_word_i] <= wr_data_i;
        if (meta_en_i) tag_q[wr_index_i] <= meta_tag_i;
    end
endmodule

// File: rtl/assoc_cache.sv
// N-way set-associative write-back cache with age-based LRU and a
// word-by-word request/ready memory port.
module assoc_cache
    import cache_pkg::*;
#(
    parameter int TAG_WIDTH    = `CACHE_T,
    parameter int SET_WIDTH    = `CACHE_S,
    parameter int OFFSET_WIDTH = `CACHE_B,
    parameter int WAYS         = `CACHE_E
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        input_ready,
    input  logic        w_en,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic        hit,
    output logic [31:0] read_data,
    output logic        m_req,
    output logic        m_wen,
    output logic [31:0] maddr,
    output logic [31:0] mwrite_data,
    input  logic [31:0] mread_data,
    input  logic        m_ready
);
    localparam int SETS = 2**SET_WIDTH;
    localparam int WW   = OFFSET_WIDTH-2;
    localparam int AW   = age_width(WAYS);
    localparam logic [WW-1:0] LAST   = {WW{1'b1}};
    localparam logic [AW-1:0] OLDEST = AW'(WAYS-1);

    state_t        state_q, state_d;
    logic [WW-1:0] k_q, k_d;
    logic [AW-1:0] victim_q, victim_d;
    logic [AW-1:0] age_q [SETS][WAYS];
    logic [AW-1:0] age_d [SETS][WAYS];

    logic [TAG_WIDTH-1:0] tag;
    logic [SET_WIDTH-1:0] index;
    logic [WW-1:0]        word, rd_word, wr_word;
    logic                 en, wr_dirty, lru_en;
    logic [31:0]          wr_data;
    logic [AW-1:0]        hit_way, inv_way, old_way, victim_sel, lru_way;
    logic                 hit_any, inv_any;

    logic [WAYS-1:0]                w_match, w_valid, w_dirty, w_we, w_meta;
    logic [WAYS-1:0][TAG_WIDTH-1:0] w_tag;
    logic [WAYS-1:0][31:0]          w_word;

    assign tag     = addr[31:32-TAG_WIDTH];
    assign index   = addr[31-TAG_WIDTH:OFFSET_WIDTH];
    assign word    = addr[OFFSET_WIDTH-1:2];
    assign en      = input_ready & ~stall;
    // During write-back the read port streams the victim line by beat.
    assign rd_word = (state_q == IDLE) ? word : k_q;

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        cache_way #(
            .TAG_WIDTH(TAG_WIDTH), .SET_WIDTH(SET_WIDTH), .OFFSET_WIDTH(OFFSET_WIDTH)
        ) u_way (
            .clk(clk), .reset(reset),
            .rd_index_i(index), .rd_word_i(rd_word), .cmp_tag_i(tag),
            .match_o(w_match[g]), .valid_o(w_valid[g]), .dirty_o(w_dirty[g]),
            .tag_o(w_tag[g]), .word_o(w_word[g]),
            .wr_en_i(w_we[g]), .wr_index_i(index), .wr_word_i(wr_word),
            .wr_data_i(wr_data), .wr_dirty_i(wr_dirty),
            .meta_en_i(w_meta[g]), .meta_tag_i(tag)
        );
    end

    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        inv_any = 1'b0;
        inv_way = '0;
        old_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (w_match[w]) begin
                hit_any = 1'b1;
                hit_way = AW'(w);
            end
            if (age_q[index][w] == OLDEST) old_way = AW'(w);
        end
        for (int w = WAYS-1; w >= 0; w--) begin
            if (!w_valid[w]) begin
                inv_any = 1'b1;
                inv_way = AW'(w);
            end
        end
        victim_sel = inv_any ? inv_way : old_way;
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        victim_d    = victim_q;
        hit         = 1'b0;
        read_data   = '0;
        m_req       = 1'b0;
        m_wen       = 1'b0;
        maddr       = '0;
        mwrite_data = '0;
        w_we        = '0;
        w_meta      = '0;
        wr_word     = word;
        wr_data     = write_data;
        wr_dirty    = 1'b0;
        lru_en      = 1'b0;
        lru_way     = hit_way;
        case (state_q)
            IDLE: if (en) begin
                if (hit_any) begin
                    hit       = 1'b1;
                    read_data = w_word[hit_way];
                    lru_en    = 1'b1;
                    if (w_en) begin
                        w_we[hit_way] = 1'b1;
                        wr_dirty      = 1'b1;
                    end
                end else begin
                    victim_d = victim_sel;
                    state_d  = (w_valid[victim_sel] && w_dirty[victim_sel]) ? WRITEBACK : REFILL;
                end
            end
            WRITEBACK: begin
                m_req       = 1'b1;
                m_wen       = 1'b1;
                maddr       = {w_tag[victim_q], index, k_q, 2'b00};
                mwrite_data = w_word[victim_q];
                if (m_ready) begin
                    k_d = k_q + 1'b1;
                    if (k_q == LAST) state_d = REFILL;
                end
            end
            REFILL: begin
                m_req = 1'b1;
                maddr = {tag, index, k_q, 2'b00};
                if (m_ready) begin
                    w_we[victim_q] = 1'b1;
                    wr_word        = k_q;
                    wr_data        = mread_data;
                    k_d            = k_q + 1'b1;
                    if (k_q == LAST) begin
                        w_meta[victim_q] = 1'b1;
                        lru_en           = 1'b1;
                        lru_way          = victim_q;
                        state_d          = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Touched way becomes youngest; everything younger than it ages by one.
    always_comb begin
        age_d = age_q;
        if (lru_en) begin
            for (int j = 0; j < WAYS; j++)
                if (age_q[index][j] < age_q[index][lru_way])
                    age_d[index][j] = age_q[index][j] + 1'b1;
            age_d[index][lru_way] = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            k_q      <= '0;
            victim_q <= '0;
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    age_q[s][w] <= AW'(w);
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            victim_q <= victim_d;
            age_q    <= age_d;
        end
    end
endmodule

// File: tb/tb_assoc_cache.sv
// Scoreboard bench for assoc_cache: expected memory beats are queued with
// the stimulus and matched against beats the DUT actually issues.
module tb_assoc_cache;
    typedef struct packed {
        logic        wen;
        logic [31:0] a;
        logic [31:0] d;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset, stall, input_ready, w_en, m_ready;
    logic [31:0] addr, write_data;
    logic        hit, m_req, m_wen;
    logic [31:0] read_data, maddr, mwrite_data, mread_data;

    int tests = 0, fails = 0, cyc = 0, last_beat_cyc = 0;
    logic        s_hit, s_mreq, s_mwen;
    logic [31:0] s_rdata, s_maddr, s_mwdata;
    beat_t exp_q[$], obs_q[$];

    assign mread_data = maddr;
    always #5 clk = ~clk;

    assoc_cache dut (
        .clk(clk), .reset(reset), .stall(stall), .input_ready(input_ready),
        .w_en(w_en), .addr(addr), .write_data(write_data),
        .hit(hit), .read_data(read_data), .m_req(m_req), .m_wen(m_wen),
        .maddr(maddr), .mwrite_data(mwrite_data),
        .mread_data(mread_data), .m_ready(m_ready)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got running want done");
        $fatal(1);
    end

    // Sample on the falling edge, log accepted beats, return after the rise.
    task automatic step();
        @(negedge clk);
        s_hit = hit; s_rdata = read_data; s_mreq = m_req;
        s_mwen = m_wen; s_maddr = maddr; s_mwdata = mwrite_data;
        cyc++;
        if (m_req && m_ready) begin
            obs_q.push_back({m_wen, maddr, mwrite_data});
            last_beat_cyc = cyc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_line(input logic wen, input logic [31:0] base);
        for (int i = 0; i < 4; i++) exp_q.push_back({wen, base + 32'(4*i), base + 32'(4*i)});
    endtask

    task automatic do_access(input logic [31:0] a, input logic we, input logic [31:0] wd,
                             output bit ok, output logic [31:0] rd, output int n);
        addr = a; w_en = we; write_data = wd; input_ready = 1'b1;
        ok = 1'b0; rd = '0; n = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            n++;
            if (s_hit) begin
                ok = 1'b1;
                rd = s_rdata;
                break;
            end
        end
        input_ready = 1'b0; w_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; input_ready = 1'b1; w_en = 1'b0;
        addr = 32'h40; write_data = '0; m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({hit, m_req, m_wen, read_data, maddr, mwrite_data} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got hit=%b req=%b wen=%b rd=%h ma=%h wd=%h want all 0",
                     hit, m_req, m_wen, read_data, maddr, mwrite_data);
        end
        input_ready = 1'b0;
        reset = 1'b0;
        step();
        tests++;
        if ({s_hit, s_mreq, s_mwen, s_rdata, s_maddr, s_mwdata} !== '0) begin
            fails++;
            $display("FAIL post_reset_idle: got hit=%b req=%b rd=%h ma=%h want all 0",
                     s_hit, s_mreq, s_rdata, s_maddr);
        end
    endtask

    task automatic test_refill();
        bit ok;
        beat_t e, o;
        exp_q.delete(); obs_q.delete();
        push_line(1'b0, 32'h40);
        addr = 32'h40; w_en = 1'b0; input_ready = 1'b1;
        step();
        tests++;
        if (s_hit !== 1'b0 || s_mreq !== 1'b0) begin
            fails++;
            $display("FAIL t1_first_cycle: got hit=%b req=%b want 0 0", s_hit, s_mreq);
        end
        ok = 1'b0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (s_hit) begin ok = 1'b1; break; end
        end
        tests++;
        if (!ok || s_rdata !== 32'h40) begin
            fails++;
            $display("FAIL t1_refill_hit: got ok=%b rd=%h want 1 00000040", ok, s_rdata);
        end
        tests++;
        if (cyc != last_beat_cyc + 1) begin
            fails++;
            $display("FAIL t1_latency: got hit at %0d want %0d", cyc, last_beat_cyc + 1);
        end
        addr = 32'h44;
        step();
        tests++;
        if (s_hit !== 1'b1 || s_rdata !== 32'h44) begin
            fails++;
            $display("FAIL t1_read_44: got hit=%b rd=%h want 1 00000044", s_hit, s_rdata);
        end
        input_ready = 1'b0;
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL t1_beat_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests++;
            if (o.wen !== e.wen || o.a !== e.a) begin
                fails++;
                $display("FAIL t1_beat: got wen=%b a=%h want wen=%b a=%h", o.wen, o.a, e.wen, e.a);
            end
        end
    endtask

    task automatic test_write_hit();
        addr = 32'h44; w_en = 1'b1; write_data = 32'hDEADBEEF; input_ready = 1'b1;
        step();
        tests++;
        if (s_hit !== 1'b1 || s_mreq !== 1'b0) begin
            fails++;
            $display("FAIL t2_write_hit: got hit=%b req=%b want 1 0", s_hit, s_mreq);
        end
        w_en = 1'b0;
        step();
        tests++;
        if (s_hit !== 1'b1 || s_rdata !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL t2_readback: got hit=%b rd=%h want 1 deadbeef", s_hit, s_rdata);
        end
        input_ready = 1'b0;
    endtask

    task automatic test_lru_evict();
        bit ok;
        logic [31:0] rd;
        int n;
        beat_t e, o;
        exp_q.delete(); obs_q.delete();
        push_line(1'b0, 32'h80);
        do_access(32'h80, 1'b0, '0, ok, rd, n);
        tests++;
        if (!ok || rd !== 32'h80) begin
            fails++;
            $display("FAIL t3_fill_80: got ok=%b rd=%h want 1 00000080", ok, rd);
        end
        do_access(32'h40, 1'b0, '0, ok, rd, n);
        tests++;
        if (!ok || n != 1 || rd !== 32'h40) begin
            fails++;
            $display("FAIL t3_hit_40: got ok=%b n=%0d rd=%h want 1 1 00000040", ok, n, rd);
        end
        push_line(1'b0, 32'hC0);
        do_access(32'hC0, 1'b0, '0, ok, rd, n);
        tests++;
        if (!ok || n != 6 || rd !== 32'hC0) begin
            fails++;
            $display("FAIL t3_clean_evict: got ok=%b n=%0d rd=%h want 1 6 000000c0", ok, n, rd);
        end
        exp_q.push_back({1'b1, 32'h40, 32'h40});
        exp_q.push_back({1'b1, 32'h44, 32'hDEADBEEF});
        exp_q.push_back({1'b1, 32'h48, 32'h48});
        exp_q.push_back({1'b1, 32'h4C, 32'h4C});
        push_line(1'b0, 32'h00);
        do_access(32'h00, 1'b0, '0, ok, rd, n);
        tests++;
        if (!ok || n != 10) begin
            fails++;
            $display("FAIL t3_dirty_evict: got ok=%b n=%0d want 1 10", ok, n);
        end
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL t3_beat_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests++;
            if (o.wen !== e.wen || o.a !== e.a || (e.wen && o.d !== e.d)) begin
                fails++;
                $display("FAIL t3_beat: got %b/%h/%h want %b/%h/%h", o.wen, o.a, o.d, e.wen, e.a, e.d);
            end
        end
    endtask

    task automatic test_ready_stall();
        int low, n58;
        bit ok;
        obs_q.delete();
        addr = 32'h50; w_en = 1'b0; input_ready = 1'b1; m_ready = 1'b1;
        low = 0; n58 = 0; ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (s_hit) begin ok = 1'b1; break; end
            if (s_mreq && s_maddr == 32'h58) n58++;
            if (obs_q.size() == 2 && low < 3) begin
                m_ready = 1'b0;
                low++;
            end else begin
                m_ready = 1'b1;
            end
        end
        m_ready = 1'b1;
        input_ready = 1'b0;
        tests++;
        if (!ok || s_rdata !== 32'h50) begin
            fails++;
            $display("FAIL t4_hit: got ok=%b rd=%h want 1 00000050", ok, s_rdata);
        end
        tests++;
        if (n58 != 4) begin
            fails++;
            $display("FAIL t4_hold_cycles: got %0d want 4", n58);
        end
        tests++;
        if (cyc != last_beat_cyc + 1 || obs_q.size() != 4) begin
            fails++;
            $display("FAIL t4_completion: got hit %0d beats %0d want hit %0d beats 4",
                     cyc, obs_q.size(), last_beat_cyc + 1);
        end
    endtask

    task automatic test_reset_mid_wb();
        bit ok, hit_wb;
        logic [31:0] rd;
        int n;
        do_access(32'h50, 1'b1, 32'hCAFE0000, ok, rd, n);
        do_access(32'h90, 1'b0, '0, ok, rd, n);
        tests++;
        if (!ok || rd !== 32'h90) begin
            fails++;
            $display("FAIL t5_fill_90: got ok=%b rd=%h want 1 00000090", ok, rd);
        end
        obs_q.delete();
        addr = 32'hD0; input_ready = 1'b1; hit_wb = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (obs_q.size() == 1) begin hit_wb = 1'b1; break; end
        end
        tests++;
        if (!hit_wb || obs_q[0] !== {1'b1, 32'h50, 32'hCAFE0000}) begin
            fails++;
            $display("FAIL t5_wb_beat0: got seen=%b beat=%h want 1 %h", hit_wb,
                     (obs_q.size() > 0) ? obs_q[0] : '0, {1'b1, 32'h50, 32'hCAFE0000});
        end
        reset = 1'b1;
        #1;
        tests++;
        if (m_req !== 1'b0) begin
            fails++;
            $display("FAIL t5_async_drop: got m_req=%b want 0", m_req);
        end
        input_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        obs_q.delete();
        do_access(32'h50, 1'b0, '0, ok, rd, n);
        tests++;
        if (!ok || n != 6 || rd !== 32'h50) begin
            fails++;
            $display("FAIL t5_refetch: got ok=%b n=%0d rd=%h want 1 6 00000050", ok, n, rd);
        end
        tests++;
        if (obs_q.size() != 4 || obs_q[0].wen !== 1'b0 || obs_q[0].a !== 32'h50) begin
            fails++;
            $display("FAIL t5_refill_beats: got n=%0d first=%h want 4 refill from 00000050",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0].a : '0);
        end
    endtask

    task automatic test_stall();
        stall = 1'b1; input_ready = 1'b1; w_en = 1'b0; addr = 32'h100;
        for (int c = 0; c < 4; c++) begin
            step();
            tests++;
            if (s_mreq !== 1'b0 || s_hit !== 1'b0) begin
                fails++;
                $display("FAIL t6_stall_miss: got req=%b hit=%b want 0 0", s_mreq, s_hit);
            end
        end
        addr = 32'h54; w_en = 1'b1; write_data = 32'h12345678;
        for (int c = 0; c < 3; c++) begin
            step();
            tests++;
            if (s_hit !== 1'b0) begin
                fails++;
                $display("FAIL t6_stall_write: got hit=%b want 0", s_hit);
            end
        end
        stall = 1'b0; w_en = 1'b0;
        step();
        tests++;
        if (s_hit !== 1'b1 || s_rdata !== 32'h54) begin
            fails++;
            $display("FAIL t6_readback: got hit=%b rd=%h want 1 00000054", s_hit, s_rdata);
        end
        input_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_refill();
        test_write_hit();
        test_lru_evict();
        test_ready_stall();
        test_reset_mid_wb();
        test_stall();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
